// File: rtl/ocpi_wsi_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : ocpi_wsi_pkg
// Purpose: OpenCPI WSI master-side encodings and field widths shared by the
//          ADC packer and its buffer, plus the packer FSM state type.
// Ports  : none (package)
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package ocpi_wsi_pkg;

  localparam int MCMD_W      = 3;
  localparam int MDATA_W     = 32;
  localparam int MBYTEEN_W   = 4;
  localparam int MREQINFO_W  = 8;
  localparam int MBURSTLEN_W = 12;

  typedef enum logic [MCMD_W-1:0] {
    MCMD_IDLE  = 3'd0,
    MCMD_WRITE = 3'd1
  } mcmd_t;

  localparam logic [MBYTEEN_W-1:0] BYTEEN_ALL  = 4'hF;
  localparam logic [MBYTEEN_W-1:0] BYTEEN_NONE = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_FLUSH = 2'd2
  } packer_state_t;

endpackage : ocpi_wsi_pkg
`default_nettype wire

// File: rtl/adc_wsi_fifo.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : adc_wsi_fifo
// Purpose: Synchronous sample buffer with registered occupancy count and
//          full/empty flags. Head word is presented combinationally on rdData.
//          A push while full is accepted only when a pop happens on the same
//          edge. clear empties the buffer in one cycle and wins over push/pop.
// Ports  : CLK, RST_N (async active-low), clear, push, wrData, pop,
//          rdData (head), count, full, empty
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module adc_wsi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  logic w_doPop;
  logic w_doPush;

  assign empty   = (r_count == '0);
  assign full    = (r_count == C_DEPTH);
  assign count   = r_count;
  assign rdData  = r_mem[r_rdPtr];

  // Popping frees a slot on the same edge, so a full buffer can still take a word.
  assign w_doPop  = pop && !empty && !clear;
  assign w_doPush = push && (!full || w_doPop) && !clear;

  always_ff @(posedge CLK) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= wrData;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule : adc_wsi_fifo
`default_nettype wire

// File: rtl/adc_wsi_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : adc_wsi_packer
// Purpose: Buffers packed ADC sample words and emits them as fixed-length,
//          precise WSI write bursts of MSG_WORDS words. Words arriving while
//          the buffer is full are dropped and counted (saturating).
// Ports  : CLK, RST_N (async active-low)
//          enable, adc_valid, adc_data[31:0]           - capture side
//          wsi_m_adc_* (MCmd, MReqLast, MBurstPrecise, MBurstLength, MData,
//          MByteEn, MReqInfo, SThreadBusy, MReset_n, SReset_n) - WSI master
//          overflow_count[15:0], msg_count[31:0]       - status
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module adc_wsi_packer
  import ocpi_wsi_pkg::*;
#(
  parameter int         MSG_WORDS  = 16,
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] OPCODE     = 8'h00
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        adc_valid,
  input  logic [31:0] adc_data,
  output logic [2:0]  wsi_m_adc_MCmd,
  output logic        wsi_m_adc_MReqLast,
  output logic        wsi_m_adc_MBurstPrecise,
  output logic [11:0] wsi_m_adc_MBurstLength,
  output logic [31:0] wsi_m_adc_MData,
  output logic [3:0]  wsi_m_adc_MByteEn,
  output logic [7:0]  wsi_m_adc_MReqInfo,
  input  logic        wsi_m_adc_SThreadBusy,
  output logic        wsi_m_adc_MReset_n,
  input  logic        wsi_m_adc_SReset_n,
  output logic [15:0] overflow_count,
  output logic [31:0] msg_count
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int WCNT_W = $clog2(MSG_WORDS + 1);
  localparam logic [CNT_W-1:0]  C_MSG_CNT  = CNT_W'(MSG_WORDS);
  localparam logic [WCNT_W-1:0] C_MSG_WCNT = WCNT_W'(MSG_WORDS);
  localparam logic [WCNT_W-1:0] C_LAST_IDX = WCNT_W'(MSG_WORDS - 1);

  // Buffer interface
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic [31:0]      w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_overflow;

  // FSM
  packer_state_t     r_state;
  packer_state_t     nextState;
  logic [WCNT_W-1:0] r_wordCnt;
  logic [WCNT_W-1:0] nextWordCnt;
  logic [WCNT_W-1:0] w_baseCnt;
  logic              w_issue;
  logic              w_msgDone;

  // Registered WSI request outputs
  mcmd_t       r_mCmd;
  mcmd_t       nextMCmd;
  logic        r_mReqLast;
  logic        nextMReqLast;
  logic [31:0] r_mData;
  logic [31:0] nextMData;
  logic [3:0]  r_mByteEn;
  logic [3:0]  nextMByteEn;

  logic        r_mReset_n;
  logic [15:0] r_overflowCnt;
  logic [31:0] r_msgCnt;

  //----------------------------------------------------------------------------
  // Sample buffer
  //----------------------------------------------------------------------------
  assign w_push     = adc_valid && enable && (!w_full || w_pop) && !w_clear;
  assign w_overflow = adc_valid && enable && w_full && !w_pop && !w_clear;

  adc_wsi_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .clear  (w_clear),
    .push   (w_push),
    .wrData (adc_data),
    .pop    (w_pop),
    .rdData (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  //----------------------------------------------------------------------------
  // FSM state register
  //----------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_wordCnt  <= '0;
      r_mCmd     <= MCMD_IDLE;
      r_mReqLast <= 1'b0;
      r_mData    <= '0;
      r_mByteEn  <= BYTEEN_NONE;
    end else begin
      r_state    <= nextState;
      r_wordCnt  <= nextWordCnt;
      r_mCmd     <= nextMCmd;
      r_mReqLast <= nextMReqLast;
      r_mData    <= nextMData;
      r_mByteEn  <= nextMByteEn;
    end
  end

  //----------------------------------------------------------------------------
  // FSM next-state and next-output logic
  //----------------------------------------------------------------------------
  always_comb begin
    nextState    = r_state;
    nextWordCnt  = r_wordCnt;
    nextMCmd     = MCMD_IDLE;
    nextMReqLast = 1'b0;
    nextMData    = '0;
    nextMByteEn  = BYTEEN_NONE;
    w_baseCnt    = r_wordCnt;
    w_issue      = 1'b0;
    w_pop        = 1'b0;
    w_clear      = 1'b0;
    w_msgDone    = 1'b0;

    if (!wsi_m_adc_SReset_n) begin
      // Slave in reset: abandon any burst and hold the buffer empty.
      nextState   = ST_IDLE;
      nextWordCnt = '0;
      w_clear     = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_count >= C_MSG_CNT) begin
            // The first word is issued on the same edge as the transition so
            // the burst starts with no dead cycle.
            nextState = ST_SEND;
            w_baseCnt = '0;
            w_issue   = !wsi_m_adc_SThreadBusy;
          end
        end
        ST_SEND: begin
          w_baseCnt = r_wordCnt;
          w_issue   = !wsi_m_adc_SThreadBusy && !w_empty
                      && (r_wordCnt < C_MSG_WCNT);
        end
        ST_FLUSH: begin
          w_clear   = 1'b1;
          nextState = ST_IDLE;
        end
        default: begin
          nextState = ST_IDLE;
        end
      endcase

      if (nextState == ST_SEND) begin
        nextWordCnt = w_baseCnt;
      end

      if (w_issue) begin
        w_pop        = 1'b1;
        nextMCmd     = MCMD_WRITE;
        nextMData    = w_head;
        nextMByteEn  = BYTEEN_ALL;
        nextMReqLast = (w_baseCnt == C_LAST_IDX);
        nextWordCnt  = w_baseCnt + WCNT_W'(1);
        if (w_baseCnt == C_LAST_IDX) begin
          // Disabled mid-message: finish the burst, then discard leftovers.
          w_msgDone = 1'b1;
          nextState = enable ? ST_IDLE : ST_FLUSH;
        end
      end
    end
  end

  //----------------------------------------------------------------------------
  // Status counters and master reset
  //----------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_overflowCnt <= '0;
      r_msgCnt      <= '0;
      r_mReset_n    <= 1'b0;
    end else begin
      r_mReset_n <= 1'b1;
      if (w_overflow && (r_overflowCnt != 16'hFFFF)) begin
        r_overflowCnt <= r_overflowCnt + 16'd1;
      end
      if (w_msgDone) begin
        r_msgCnt <= r_msgCnt + 32'd1;
      end
    end
  end

  //----------------------------------------------------------------------------
  // Outputs
  //----------------------------------------------------------------------------
  assign wsi_m_adc_MCmd          = r_mCmd;
  assign wsi_m_adc_MReqLast      = r_mReqLast;
  assign wsi_m_adc_MData         = r_mData;
  assign wsi_m_adc_MByteEn       = r_mByteEn;
  assign wsi_m_adc_MBurstPrecise = 1'b1;
  assign wsi_m_adc_MBurstLength  = MBURSTLEN_W'(MSG_WORDS);
  assign wsi_m_adc_MReqInfo      = OPCODE;
  assign wsi_m_adc_MReset_n      = r_mReset_n;
  assign overflow_count          = r_overflowCnt;
  assign msg_count               = r_msgCnt;

endmodule : adc_wsi_packer
`default_nettype wire

// File: tb/tb_adc_wsi_packer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_adc_wsi_packer
// Purpose: Directed self-checking bench for adc_wsi_packer (defaults:
//          MSG_WORDS=16, FIFO_DEPTH=32, OPCODE=8'h00).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_adc_wsi_packer;

  localparam int MSG = 16;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic        adc_valid = 1'b0;
  logic [31:0] adc_data = '0;
  logic [2:0]  MCmd;
  logic        MReqLast;
  logic        MBurstPrecise;
  logic [11:0] MBurstLength;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic [7:0]  MReqInfo;
  logic        SThreadBusy = 1'b0;
  logic        MReset_n;
  logic        SReset_n = 1'b1;
  logic [15:0] overflow_count;
  logic [31:0] msg_count;

  adc_wsi_packer dut (
    .CLK                     (CLK),
    .RST_N                   (RST_N),
    .enable                  (enable),
    .adc_valid               (adc_valid),
    .adc_data                (adc_data),
    .wsi_m_adc_MCmd          (MCmd),
    .wsi_m_adc_MReqLast      (MReqLast),
    .wsi_m_adc_MBurstPrecise (MBurstPrecise),
    .wsi_m_adc_MBurstLength  (MBurstLength),
    .wsi_m_adc_MData         (MData),
    .wsi_m_adc_MByteEn       (MByteEn),
    .wsi_m_adc_MReqInfo      (MReqInfo),
    .wsi_m_adc_SThreadBusy   (SThreadBusy),
    .wsi_m_adc_MReset_n      (MReset_n),
    .wsi_m_adc_SReset_n      (SReset_n),
    .overflow_count          (overflow_count),
    .msg_count               (msg_count)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int lastSetCyc = 0;

  logic [31:0] wrData [$];
  logic        wrLast [$];
  logic [3:0]  wrBe   [$];
  int          wrCyc  [$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Log every WRITE beat seen on the WSI request side.
  always @(negedge CLK) begin
    if (MCmd == 3'd1) begin
      wrData.push_back(MData);
      wrLast.push_back(MReqLast);
      wrBe.push_back(MByteEn);
      wrCyc.push_back(cyc);
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clearLog();
    wrData.delete();
    wrLast.delete();
    wrBe.delete();
    wrCyc.delete();
  endtask

  task automatic sendWords(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      adc_valid = 1'b1;
      adc_data  = 32'(base + i);
      lastSetCyc = cyc;
    end
    @(negedge CLK);
    adc_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic waitWrite(input logic [31:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge CLK);
      if (MCmd == 3'd1 && MData == d) found = 1'b1;
    end
    checkEq("wait_write", 32'(found), 32'd1);
  endtask

  // Expected stream: consecutive values from base, last on every MSG-th beat.
  task automatic checkStream(input string tag, input int base, input int n);
    int badBe;
    badBe = 0;
    checkEq({tag, "_nwrites"}, 32'(wrData.size()), 32'(n));
    for (int i = 0; i < wrData.size() && i < n; i++) begin
      checkEq({tag, "_data"}, wrData[i], 32'(base + i));
      checkEq({tag, "_last"}, 32'(wrLast[i]), ((i % MSG) == MSG - 1) ? 32'd1 : 32'd0);
      if (wrBe[i] != 4'hF) badBe++;
    end
    checkEq({tag, "_byteen"}, 32'(badBe), 32'd0);
  endtask

  initial begin
    // ---- Reset state
    #2;
    checkEq("rst_mcmd", 32'(MCmd), 32'd0);
    checkEq("rst_last", 32'(MReqLast), 32'd0);
    checkEq("rst_data", MData, 32'd0);
    checkEq("rst_be", 32'(MByteEn), 32'd0);
    checkEq("rst_mreset", 32'(MReset_n), 32'd0);
    checkEq("rst_ovf", 32'(overflow_count), 32'd0);
    checkEq("rst_msg", msg_count, 32'd0);
    checkEq("burstlen", 32'(MBurstLength), 32'd16);
    checkEq("precise", 32'(MBurstPrecise), 32'd1);
    checkEq("reqinfo", 32'(MReqInfo), 32'd0);
    waitCycles(2);
    RST_N = 1'b1;
    #1 checkEq("mreset_before_edge", 32'(MReset_n), 32'd0);
    @(negedge CLK);
    checkEq("mreset_after_edge", 32'(MReset_n), 32'd1);
    enable = 1'b1;

    // ---- Basic message, back-to-back, minimum latency
    clearLog();
    sendWords(0, 16);
    waitCycles(25);
    checkStream("basic", 0, 16);
    if (wrCyc.size() == 16) begin
      checkEq("basic_latency", 32'(wrCyc[0] - lastSetCyc), 32'd2);
      checkEq("basic_b2b", 32'(wrCyc[15] - wrCyc[0]), 32'd15);
    end
    checkEq("basic_msg", msg_count, 32'd1);

    // ---- Slave busy for words 4..6
    clearLog();
    sendWords(100, 16);
    waitWrite(32'd103);
    SThreadBusy = 1'b1;
    waitCycles(3);
    SThreadBusy = 1'b0;
    waitCycles(25);
    checkStream("busy", 100, 16);
    if (wrCyc.size() == 16) checkEq("busy_span", 32'(wrCyc[15] - wrCyc[0] + 1), 32'd19);
    checkEq("busy_msg", msg_count, 32'd2);

    // ---- Permanent busy, overflow, disabled input ignored
    clearLog();
    SThreadBusy = 1'b1;
    sendWords(200, 40);
    waitCycles(2);
    checkEq("ovf_count", 32'(overflow_count), 32'd8);
    checkEq("ovf_full", 32'(dut.uFifo.full), 32'd1);
    checkEq("ovf_level", 32'(dut.uFifo.count), 32'd32);
    checkEq("ovf_nowrite", 32'(wrData.size()), 32'd0);
    enable = 1'b0;
    sendWords(900, 3);
    checkEq("ovf_disabled_ignored", 32'(overflow_count), 32'd8);
    enable = 1'b1;
    SThreadBusy = 1'b0;
    waitCycles(50);
    checkStream("drain", 200, 32);
    checkEq("drain_msg", msg_count, 32'd4);
    checkEq("drain_empty", 32'(dut.uFifo.count), 32'd0);

    // ---- Enable dropped mid-message: finish burst then flush residue
    clearLog();
    sendWords(300, 24);
    waitWrite(32'd308);
    enable = 1'b0;
    waitCycles(30);
    checkStream("flush", 300, 16);
    checkEq("flush_msg", msg_count, 32'd5);
    checkEq("flush_empty", 32'(dut.uFifo.count), 32'd0);
    enable = 1'b1;

    // ---- Slave reset at word 5
    clearLog();
    sendWords(400, 16);
    waitWrite(32'd404);
    SReset_n = 1'b0;
    @(negedge CLK);
    checkEq("sreset_mcmd", 32'(MCmd), 32'd0);
    checkEq("sreset_empty", 32'(dut.uFifo.count), 32'd0);
    checkEq("sreset_msg", msg_count, 32'd5);
    checkEq("sreset_nwrites", 32'(wrData.size()), 32'd5);
    waitCycles(2);
    SReset_n = 1'b1;
    clearLog();
    sendWords(500, 16);
    waitCycles(25);
    checkStream("resume", 500, 16);
    checkEq("resume_msg", msg_count, 32'd6);

    // ---- Async reset mid-message
    clearLog();
    sendWords(600, 16);
    waitWrite(32'd603);
    #2 RST_N = 1'b0;
    #1;
    checkEq("arst_mcmd", 32'(MCmd), 32'd0);
    checkEq("arst_data", MData, 32'd0);
    checkEq("arst_be", 32'(MByteEn), 32'd0);
    checkEq("arst_last", 32'(MReqLast), 32'd0);
    checkEq("arst_mreset", 32'(MReset_n), 32'd0);
    checkEq("arst_msg", msg_count, 32'd0);
    checkEq("arst_ovf", 32'(overflow_count), 32'd0);
    checkEq("arst_empty", 32'(dut.uFifo.count), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1 checkEq("arst_mreset_held", 32'(MReset_n), 32'd0);
    @(negedge CLK);
    checkEq("arst_mreset_rise", 32'(MReset_n), 32'd1);
    clearLog();
    sendWords(700, 16);
    waitCycles(25);
    checkStream("post_rst", 700, 16);
    checkEq("post_rst_msg", msg_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_adc_wsi_packer
`default_nettype wire
